time_display_mux: RTL and testbench



---
 rtl/display_pkg.sv | 49 ++++
 rtl/seg7_decode.sv | 32 +++
 rtl/time_display_mux.sv | 119 +++++++++++
 tb/tb_time_display_mux.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Purpose  : Seven-segment codes, digit slot indices and BCD split helper
// Revision : 1.0  initial release
// ============================================================================
package display_pkg;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd_t;

  // Priority compare against multiples of ten; values 60..63 yield tens = 6.
  function automatic bcd_t bcd_split(input logic [5:0] value);
    bcd_t       result;
    logic [5:0] rem;
    result.tens = 4'd0;
    rem         = value;
    for (int k = 6; k >= 1; k--) begin
      if (result.tens == 4'd0 && value >= 6'(k * 10)) begin
        result.tens = 4'(k);
        rem         = value - 6'(k * 10);
      end
    end
    result.ones = 4'(rem);
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_decode
// Purpose  : BCD digit to active-low seven-segment code; 10..15 blank
// Revision : 1.0  initial release
// ============================================================================
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/time_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : time_display_mux
// Purpose  : Frame-snapshotted 4-digit mm:ss multiplexer with field blink
// Revision : 1.0  initial release
// ============================================================================
module time_display_mux
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       timer,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adjust,
  input  logic       sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int C_RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int C_BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [C_RW-1:0] r_refresh_cnt;
  logic [1:0]      r_idx;
  logic [C_BW-1:0] r_blink_cnt;
  logic            r_blink_on;
  logic [5:0]      r_min_q;
  logic [5:0]      r_sec_q;
  logic            r_load_pending;

  logic            w_tc;
  logic            w_blink_wrap;
  logic            w_blank;
  bcd_t            w_min_bcd;
  bcd_t            w_sec_bcd;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg;

  assign w_tc         = (r_refresh_cnt == C_RW'(REFRESH_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == C_BW'(BLINK_DIV - 1));
  assign w_min_bcd    = bcd_split(r_min_q);
  assign w_sec_bcd    = bcd_split(r_sec_q);

  // Slots 2/3 carry minutes, so idx[1] identifies the field being scanned.
  assign w_blank = adjust & ~r_blink_on & (sel == r_idx[1]);

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      DIG_SEC_ONES: w_digit = w_sec_bcd.ones;
      DIG_SEC_TENS: w_digit = w_sec_bcd.tens;
      DIG_MIN_ONES: w_digit = w_min_bcd.ones;
      DIG_MIN_TENS: w_digit = w_min_bcd.tens;
      default:      w_digit = 4'd0;
    endcase
  end

  seg7_decode u_seg7_decode (
    .digit (w_digit),
    .seg   (w_seg)
  );

  // The scan is held during the post-reset load cycle so digit 0 of the
  // fresh snapshot still gets a full REFRESH_DIV slot.
  always_ff @(posedge timer) begin
    if (reset) begin
      r_refresh_cnt  <= '0;
      r_idx          <= DIG_SEC_ONES;
      r_min_q        <= '0;
      r_sec_q        <= '0;
      r_load_pending <= 1'b1;
    end else begin
      r_load_pending <= 1'b0;
      if (r_load_pending) begin
        r_min_q <= minutes;
        r_sec_q <= seconds;
      end else if (w_tc) begin
        r_refresh_cnt <= '0;
        r_idx         <= r_idx + 2'd1;
        if (r_idx == DIG_MIN_TENS) begin
          r_min_q <= minutes;
          r_sec_q <= seconds;
        end
      end else begin
        r_refresh_cnt <= r_refresh_cnt + C_RW'(1);
      end
    end
  end

  always_ff @(posedge timer) begin
    if (reset || !adjust) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_blink_wrap) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + C_BW'(1);
    end
  end

  always_ff @(posedge timer) begin
    if (reset || r_load_pending || w_blank) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      seg <= w_seg;
      dp  <= (r_idx == DIG_MIN_ONES) ? 1'b0 : 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_time_display_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_display_mux
// Purpose  : Directed self-checking bench for time_display_mux
// Revision : 1.0  initial release
// ============================================================================
module tb_time_display_mux;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] BL = 7'b1111111;

  logic       timer = 1'b0;
  logic       reset;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adjust;
  logic       sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int vectors     = 0;
  int miscompares = 0;

  time_display_mux #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16)
  ) dut (
    .timer   (timer),
    .reset   (reset),
    .minutes (minutes),
    .seconds (seconds),
    .adjust  (adjust),
    .sel     (sel),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  always #5 timer = ~timer;

  task automatic step();
    @(posedge timer);
    #1;
  endtask

  task automatic chk(input logic [3:0] e_an, input logic [6:0] e_seg,
                     input logic e_dp, input string tag);
    vectors++;
    assert ({an, seg, dp} === {e_an, e_seg, e_dp}) else begin
      miscompares++;
      $error("FAIL %s: an/seg/dp observed %b/%b/%b expected %b/%b/%b",
             tag, an, seg, dp, e_an, e_seg, e_dp);
    end
  endtask

  task automatic step_chk(input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp, input string tag);
    step();
    chk(e_an, e_seg, e_dp, tag);
  endtask

  // One full digit slot (4 cycles) of the given scan position.
  task automatic scan_digit(input int slot, input logic [6:0] code, input string tag);
    logic [3:0] e_an;
    logic       e_dp;
    case (slot)
      0:       begin e_an = 4'b1110; e_dp = 1'b1; end
      1:       begin e_an = 4'b1101; e_dp = 1'b1; end
      2:       begin e_an = 4'b1011; e_dp = 1'b0; end
      default: begin e_an = 4'b0111; e_dp = 1'b1; end
    endcase
    for (int i = 0; i < 4; i++) step_chk(e_an, code, e_dp, tag);
  endtask

  task automatic frame(input logic [6:0] c0, input logic [6:0] c1,
                       input logic [6:0] c2, input logic [6:0] c3, input string tag);
    scan_digit(0, c0, tag);
    scan_digit(1, c1, tag);
    scan_digit(2, c2, tag);
    scan_digit(3, c3, tag);
  endtask

  initial begin
    reset   = 1'b1;
    minutes = 6'd12;
    seconds = 6'd34;
    adjust  = 1'b0;
    sel     = 1'b0;

    for (int i = 0; i < 10; i++) step_chk(4'b1111, BL, 1'b1, "reset_held");

    reset = 1'b0;
    step();
    frame(S4, S3, S2, S1, "scan_12_34");

    scan_digit(0, S4, "snap_before");
    scan_digit(1, S3, "snap_before");
    step_chk(4'b1011, S2, 1'b0, "snap_before");
    seconds = 6'd35;
    for (int i = 0; i < 3; i++) step_chk(4'b1011, S2, 1'b0, "snap_hold");
    scan_digit(3, S1, "snap_hold");
    frame(S5, S3, S2, S1, "snap_12_35");

    minutes = 6'd60;
    seconds = 6'd59;
    frame(S5, S3, S2, S1, "pre_60_59");
    frame(S9, S5, S0, S6, "bnd_60_59");
    minutes = 6'd63;
    frame(S9, S5, S0, S6, "pre_63_59");
    frame(S9, S5, S3, S6, "bnd_63_59");
    minutes = 6'd0;
    seconds = 6'd0;
    frame(S9, S5, S3, S6, "pre_00_00");
    frame(S0, S0, S0, S0, "bnd_00_00");

    minutes = 6'd12;
    seconds = 6'd34;
    adjust  = 1'b1;
    sel     = 1'b1;
    frame(S0, S0, S0, S0, "blink_vis");
    scan_digit(0, S4, "blink_off_sec");
    scan_digit(1, S3, "blink_off_sec");
    step_chk(4'b1111, BL, 1'b1, "blink_off_min");
    step_chk(4'b1111, BL, 1'b1, "blink_off_min");
    adjust = 1'b0;
    step_chk(4'b1011, S2, 1'b0, "adjust_fall");
    step_chk(4'b1011, S2, 1'b0, "adjust_fall");
    scan_digit(3, S1, "adjust_fall");

    adjust = 1'b1;
    frame(S4, S3, S2, S1, "blink_rise_vis");
    scan_digit(0, S4, "blink2_off_sec");
    scan_digit(1, S3, "blink2_off_sec");
    for (int i = 0; i < 8; i++) step_chk(4'b1111, BL, 1'b1, "blink2_off_min");
    adjust = 1'b0;

    scan_digit(0, S4, "pre_reset");
    step_chk(4'b1101, S3, 1'b1, "pre_reset");
    reset   = 1'b1;
    seconds = 6'd47;
    step_chk(4'b1111, BL, 1'b1, "reset_mid");
    reset = 1'b0;
    step();
    frame(S7, S4, S2, S1, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
